// File: rtl/ps2_key_decoder_pkg.sv
// ps2_pkg: shared constants and FSM state type for the PS/2 key decoder.
//   PS2_BREAK   - set-2 break prefix byte (F0)
//   PS2_EXT     - set-2 extended prefix byte (E0)
//   ps2_state_e - decoder FSM states IDLE / POP / GAP
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } ps2_state_e;

    // True for either prefix byte; anything else carries a key code.
    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_BREAK) || (b == PS2_EXT);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: byte handshake between the PS/2 receiver FIFO and the
// key decoder.
//   ps2_data     - head byte of the receiver FIFO
//   ps2_ready    - FIFO non-empty
//   ps2_overflow - receiver FIFO overflow flag
//   nextdata_n   - active-low pop strobe back to the receiver
// master = receiver side, slave = decoder side.
interface ps2_key_decoder_if;

    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       nextdata_n;

    modport master (
        output ps2_data,
        output ps2_ready,
        output ps2_overflow,
        input  nextdata_n
    );

    modport slave (
        input  ps2_data,
        input  ps2_ready,
        input  ps2_overflow,
        output nextdata_n
    );

endinterface

// File: rtl/ps2_key_decoder_scan2ascii.sv
// ps2_scan2ascii: combinational set-2 scan code to ASCII lookup.
//   scan_code in 8 - set-2 make code (non-extended)
//   ascii     out 8 - lowercase a-z, 0-9, space, CR; 0x00 when unmapped
// Only built when PS2_KEY_ASCII_EN is defined.
`ifdef PS2_KEY_ASCII_EN
module ps2_scan2ascii (
    input  logic [7:0] scan_code,
    output logic [7:0] ascii
);

    // Fixed set-2 lookup table.
    always_comb begin
        ascii = 8'h00;
        case (scan_code)
            8'h1C: ascii = 8'h61; // a
            8'h32: ascii = 8'h62; // b
            8'h21: ascii = 8'h63; // c
            8'h23: ascii = 8'h64; // d
            8'h24: ascii = 8'h65; // e
            8'h2B: ascii = 8'h66; // f
            8'h34: ascii = 8'h67; // g
            8'h33: ascii = 8'h68; // h
            8'h43: ascii = 8'h69; // i
            8'h3B: ascii = 8'h6A; // j
            8'h42: ascii = 8'h6B; // k
            8'h4B: ascii = 8'h6C; // l
            8'h3A: ascii = 8'h6D; // m
            8'h31: ascii = 8'h6E; // n
            8'h44: ascii = 8'h6F; // o
            8'h4D: ascii = 8'h70; // p
            8'h15: ascii = 8'h71; // q
            8'h2D: ascii = 8'h72; // r
            8'h1B: ascii = 8'h73; // s
            8'h2C: ascii = 8'h74; // t
            8'h3C: ascii = 8'h75; // u
            8'h2A: ascii = 8'h76; // v
            8'h1D: ascii = 8'h77; // w
            8'h22: ascii = 8'h78; // x
            8'h35: ascii = 8'h79; // y
            8'h1A: ascii = 8'h7A; // z
            8'h45: ascii = 8'h30; // 0
            8'h16: ascii = 8'h31; // 1
            8'h1E: ascii = 8'h32; // 2
            8'h26: ascii = 8'h33; // 3
            8'h25: ascii = 8'h34; // 4
            8'h2E: ascii = 8'h35; // 5
            8'h36: ascii = 8'h36; // 6
            8'h3D: ascii = 8'h37; // 7
            8'h3E: ascii = 8'h38; // 8
            8'h46: ascii = 8'h39; // 9
            8'h29: ascii = 8'h20; // space
            8'h5A: ascii = 8'h0D; // enter
            default: ascii = 8'h00;
        endcase
    end

endmodule
`endif

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops bytes from the PS/2 receiver FIFO and folds F0/E0
// prefixes into one key event per key, tracking the held key so typematic
// repeats are flagged and not counted.
//   clk, resetn  - clock, synchronous active-low reset
//   ps2 (slave)  - receiver FIFO handshake (data/ready/overflow/nextdata_n)
//   key_valid    - one-cycle event strobe
//   key_code/key_ext/key_down/key_repeat/key_ascii - last event, held between events
//   press_count  - count of new (non-repeat) makes, wraps
//   ovf_sticky   - receiver overflow seen since reset
// Optional feature macro: PS2_KEY_ASCII_EN (scan-code to ASCII lookup);
// without it key_ascii is constant 0.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    ps2_key_decoder_if.slave   ps2,
    output logic               key_valid,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_down,
    output logic               key_repeat,
    output logic [7:0]         key_ascii,
    output logic [CNT_W-1:0]   press_count,
    output logic               ovf_sticky
);

    ps2_state_e       state_r;
    logic             nextdata_n_r;
    logic             brk_pend_r;
    logic             ext_pend_r;
    logic             held_vld_r;
    logic [7:0]       held_code_r;
    logic             held_ext_r;
    logic             key_valid_r;
    logic [7:0]       key_code_r;
    logic             key_ext_r;
    logic             key_down_r;
    logic             key_repeat_r;
    logic [CNT_W-1:0] press_count_r;
    logic             ovf_sticky_r;

    logic             accept_s;
    logic             accept_evt_s;
    logic             held_match_s;

    // The byte is classified on the accepting edge so the event is visible
    // in the same cycle as the pop strobe.
    always_comb begin
        accept_s     = 1'b0;
        accept_evt_s = 1'b0;
        held_match_s = 1'b0;
        if (state_r == IDLE) begin
            accept_s = ps2.ps2_ready;
        end else begin
            accept_s = 1'b0;
        end
        if (accept_s && !is_prefix(ps2.ps2_data)) begin
            accept_evt_s = 1'b1;
        end else begin
            accept_evt_s = 1'b0;
        end
        if (held_vld_r && (held_ext_r == ext_pend_r) && (held_code_r == ps2.ps2_data)) begin
            held_match_s = 1'b1;
        end else begin
            held_match_s = 1'b0;
        end
    end

    // Main FSM: IDLE accepts a byte, POP strobes nextdata_n, GAP lets the
    // receiver advance its head before the next look.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= IDLE;
            nextdata_n_r  <= 1'b1;
            brk_pend_r    <= 1'b0;
            ext_pend_r    <= 1'b0;
            held_vld_r    <= 1'b0;
            held_code_r   <= 8'h00;
            held_ext_r    <= 1'b0;
            key_valid_r   <= 1'b0;
            key_code_r    <= 8'h00;
            key_ext_r     <= 1'b0;
            key_down_r    <= 1'b0;
            key_repeat_r  <= 1'b0;
            press_count_r <= {CNT_W{1'b0}};
        end else begin
            key_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r      <= POP;
                        nextdata_n_r <= 1'b0;
                        if (ps2.ps2_data == PS2_BREAK) begin
                            brk_pend_r <= 1'b1;
                        end else if (ps2.ps2_data == PS2_EXT) begin
                            ext_pend_r <= 1'b1;
                        end else begin
                            key_valid_r <= 1'b1;
                            key_code_r  <= ps2.ps2_data;
                            key_ext_r   <= ext_pend_r;
                            key_down_r  <= !brk_pend_r;
                            brk_pend_r  <= 1'b0;
                            ext_pend_r  <= 1'b0;
                            if (!brk_pend_r) begin
                                if (held_match_s) begin
                                    key_repeat_r <= 1'b1;
                                end else begin
                                    key_repeat_r  <= 1'b0;
                                    press_count_r <= press_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                                    held_vld_r    <= 1'b1;
                                    held_code_r   <= ps2.ps2_data;
                                    held_ext_r    <= ext_pend_r;
                                end
                            end else begin
                                key_repeat_r <= 1'b0;
                                if (held_match_s) begin
                                    held_vld_r <= 1'b0;
                                end else begin
                                    held_vld_r <= held_vld_r;
                                end
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                POP: begin
                    nextdata_n_r <= 1'b1;
                    state_r      <= GAP;
                end
                GAP: begin
                    state_r <= IDLE;
                end
                default: begin
                    nextdata_n_r <= 1'b1;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    // Overflow is latched in every state, independent of the FSM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ovf_sticky_r <= 1'b0;
        end else begin
            ovf_sticky_r <= ovf_sticky_r | ps2.ps2_overflow;
        end
    end

`ifdef PS2_KEY_ASCII_EN
    logic [7:0] lut_ascii_s;
    logic [7:0] ascii_next_s;
    logic [7:0] key_ascii_r;

    ps2_scan2ascii u_scan2ascii (
        .scan_code (ps2.ps2_data),
        .ascii     (lut_ascii_s)
    );

    // Extended keys share codes with plain keys but are never printable.
    always_comb begin
        ascii_next_s = 8'h00;
        if (ext_pend_r) begin
            ascii_next_s = 8'h00;
        end else begin
            ascii_next_s = lut_ascii_s;
        end
    end

    // ASCII register tracks key_code, updated on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_ascii_r <= 8'h00;
        end else if (accept_evt_s) begin
            key_ascii_r <= ascii_next_s;
        end else begin
            key_ascii_r <= key_ascii_r;
        end
    end

    assign key_ascii = key_ascii_r;
`else
    assign key_ascii = 8'h00;
`endif

    assign ps2.nextdata_n = nextdata_n_r;
    assign key_valid      = key_valid_r;
    assign key_code       = key_code_r;
    assign key_ext        = key_ext_r;
    assign key_down       = key_down_r;
    assign key_repeat     = key_repeat_r;
    assign press_count    = press_count_r;
    assign ovf_sticky     = ovf_sticky_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: self-checking bench for ps2_key_decoder. A queue models
// the receiver FIFO; a table of single-byte vectors covers the documented
// sequences, hand-written sequences cover timing, reset and wrap, and a
// random byte stream is checked against a key-event reference model.
module tb_ps2_key_decoder;

    localparam int CNT_W = 8;
`ifdef PS2_KEY_ASCII_EN
    localparam bit ASC_EN = 1'b1;
`else
    localparam bit ASC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_down;
    logic             key_repeat;
    logic [7:0]       key_ascii;
    logic [CNT_W-1:0] press_count;
    logic             ovf_sticky;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ps2         (bus),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_down    (key_down),
        .key_repeat  (key_repeat),
        .key_ascii   (key_ascii),
        .press_count (press_count),
        .ovf_sticky  (ovf_sticky)
    );

    typedef struct packed {
        logic [7:0]       code;
        logic             ext;
        logic             down;
        logic             rep;
        logic [7:0]       ascii;
        logic [CNT_W-1:0] cnt;
    } ev_t;

    typedef struct packed {
        logic [7:0] b;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       down;
        logic       rep;
        logic [7:0] ascii;
        logic [7:0] cnt;
    } vec_t;

    logic [7:0] fifo_q[$];
    ev_t        ev_q[$];
    ev_t        exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         nd_low_cnt = 0;
    int         nd_last_low = 0;
    int         nd_prev_low = 0;
    int         ready_rise_cyc = 0;
    int         last_ev_cyc = 0;

    // reference model state
    logic             m_brk, m_ext, m_held_vld;
    logic [8:0]       m_held;
    logic [CNT_W-1:0] m_cnt;

    // receiver FIFO pop on the strobe
    always @(posedge clk) begin
        if (!bus.nextdata_n && fifo_q.size() > 0) void'(fifo_q.pop_front());
    end

    // sample DUT, then present the FIFO head
    always @(negedge clk) begin
        cyc++;
        if (resetn === 1'b1 && key_valid === 1'b1) begin
            ev_q.push_back({key_code, key_ext, key_down, key_repeat, key_ascii, press_count});
            last_ev_cyc = cyc;
        end
        if (bus.nextdata_n === 1'b0) begin
            nd_low_cnt++;
            nd_prev_low = nd_last_low;
            nd_last_low = cyc;
        end
        if (fifo_q.size() > 0) begin
            if (bus.ps2_ready !== 1'b1) ready_rise_cyc = cyc;
            bus.ps2_ready = 1'b1;
            bus.ps2_data  = fifo_q[0];
        end else begin
            bus.ps2_ready = 1'b0;
            bus.ps2_data  = 8'h00;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (fifo_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (fifo_q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d bytes left expected=0", fifo_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        m_brk = 1'b0; m_ext = 1'b0; m_held_vld = 1'b0; m_held = 9'h000;
        m_cnt = {CNT_W{1'b0}};
    endtask

    function automatic logic [7:0] ascii_ref(input logic [7:0] b);
        case (b)
            8'h1C: return 8'h61;
            8'h32: return 8'h62;
            8'h15: return 8'h71;
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            default: return 8'h00;
        endcase
    endfunction

    // key-event rules applied to one byte of the stream
    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            e.code  = b;
            e.ext   = m_ext;
            e.down  = !m_brk;
            e.rep   = e.down && m_held_vld && (m_held == {m_ext, b});
            if (e.down && !e.rep) begin
                m_cnt      = m_cnt + 1'b1;
                m_held_vld = 1'b1;
                m_held     = {m_ext, b};
            end
            if (!e.down && m_held_vld && m_held == {m_ext, b}) m_held_vld = 1'b0;
            e.cnt   = m_cnt;
            e.ascii = (ASC_EN && !m_ext) ? ascii_ref(b) : 8'h00;
            exp_q.push_back(e);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    vec_t vecs[22];
    logic [7:0] codes[7];

    initial begin
        int nd_before;
        resetn = 1'b0;
        bus.ps2_overflow = 1'b0;
        bus.ps2_ready = 1'b0;
        bus.ps2_data = 8'h00;
        vecs = '{
            '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h61, 8'd1},
            '{8'hF0, 1'b0, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h61, 8'd1},
            '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61, 8'd1},
            '{8'h15, 1'b1, 8'h15, 1'b0, 1'b1, 1'b0, 8'h71, 8'd2},
            '{8'h15, 1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 8'h71, 8'd2},
            '{8'h15, 1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 8'h71, 8'd2},
            '{8'hF0, 1'b0, 8'h15, 1'b0, 1'b1, 1'b1, 8'h71, 8'd2},
            '{8'h15, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 8'h71, 8'd2},
            '{8'h15, 1'b1, 8'h15, 1'b0, 1'b1, 1'b0, 8'h71, 8'd3},
            '{8'hE0, 1'b0, 8'h15, 1'b0, 1'b1, 1'b0, 8'h71, 8'd3},
            '{8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 8'h00, 8'd4},
            '{8'hE0, 1'b0, 8'h75, 1'b1, 1'b1, 1'b0, 8'h00, 8'd4},
            '{8'hF0, 1'b0, 8'h75, 1'b1, 1'b1, 1'b0, 8'h00, 8'd4},
            '{8'h75, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 8'h00, 8'd4},
            '{8'h29, 1'b1, 8'h29, 1'b0, 1'b1, 1'b0, 8'h20, 8'd5},
            '{8'h5A, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h0D, 8'd6},
            '{8'hF0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h0D, 8'd6},
            '{8'hF0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h0D, 8'd6},
            '{8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h0D, 8'd6},
            '{8'h5A, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h0D, 8'd7},
            '{8'hE0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h0D, 8'd7},
            '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 8'd8}
        };
        codes = '{8'h1C, 8'h32, 8'h15, 8'h75, 8'h29, 8'h5A, 8'h66};

        repeat (2) @(negedge clk);
        do_reset();
        // reset state
        chk("rst_nextdata_n", bus.nextdata_n, 1'b1);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_key_code", key_code, 8'h00);
        chk("rst_press_count", press_count, 0);
        chk("rst_ovf_sticky", ovf_sticky, 1'b0);

        // pop strobe timing for one event byte
        nd_before = nd_low_cnt;
        fifo_q.push_back(8'h1C);
        wait_drain(40);
        chk("nd_low_cycles", nd_low_cnt - nd_before, 1);
        chk("nd_low_after_accept", nd_last_low, ready_rise_cyc + 1);
        chk("valid_with_pop", last_ev_cyc, nd_last_low);
        chk("valid_one_cycle", ev_q.size(), 1);

        // table vectors from a fresh reset
        do_reset();
        foreach (vecs[i]) begin
            ev_q.delete();
            fifo_q.push_back(vecs[i].b);
            wait_drain(40);
            chk($sformatf("v%0d_events", i), ev_q.size(), vecs[i].ev);
            chk($sformatf("v%0d_code", i), key_code, vecs[i].code);
            chk($sformatf("v%0d_ext", i), key_ext, vecs[i].ext);
            chk($sformatf("v%0d_down", i), key_down, vecs[i].down);
            chk($sformatf("v%0d_repeat", i), key_repeat, vecs[i].rep);
            chk($sformatf("v%0d_ascii", i), key_ascii, ASC_EN ? vecs[i].ascii : 8'h00);
            chk($sformatf("v%0d_count", i), press_count, vecs[i].cnt);
        end

        // back-to-back bytes: one pop every 3 cycles
        do_reset();
        ev_q.delete();
        fifo_q.push_back(8'h32); fifo_q.push_back(8'h32); fifo_q.push_back(8'h32);
        wait_drain(60);
        chk("throughput_spacing", nd_last_low - nd_prev_low, 3);
        chk("b2b_events", ev_q.size(), 3);
        chk("b2b_last_repeat", key_repeat, 1'b1);
        chk("b2b_count", press_count, 1);

        // reset discards pending prefixes
        do_reset();
        fifo_q.push_back(8'hE0); fifo_q.push_back(8'hF0);
        wait_drain(40);
        do_reset();
        chk("mid_rst_code", key_code, 8'h00);
        chk("mid_rst_down", key_down, 1'b0);
        chk("mid_rst_ext", key_ext, 1'b0);
        chk("mid_rst_ascii", key_ascii, 8'h00);
        chk("mid_rst_nd", bus.nextdata_n, 1'b1);
        fifo_q.push_back(8'h1C);
        wait_drain(40);
        chk("post_rst_down", key_down, 1'b1);
        chk("post_rst_ext", key_ext, 1'b0);
        chk("post_rst_count", press_count, 1);

        // overflow stickiness
        chk("ovf_before", ovf_sticky, 1'b0);
        @(negedge clk); bus.ps2_overflow = 1'b1;
        @(negedge clk); bus.ps2_overflow = 1'b0;
        repeat (10) @(negedge clk);
        chk("ovf_sticky_held", ovf_sticky, 1'b1);
        do_reset();
        chk("ovf_cleared", ovf_sticky, 1'b0);

        // press counter wrap
        for (int i = 0; i < 255; i++) fifo_q.push_back((i % 2 == 0) ? 8'h1C : 8'h32);
        wait_drain(2000);
        chk("cnt_255", press_count, 255);
        fifo_q.push_back(8'h32);
        wait_drain(40);
        chk("cnt_wrap", press_count, 0);

        // random stream against the reference model
        do_reset();
        ev_q.delete();
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            else b = codes[$urandom_range(0, 6)];
            fifo_q.push_back(b);
            model_byte(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        wait_drain(3000);
        chk("rand_event_count", ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
            chk($sformatf("rand_ev%0d", i), ev_q[i], exp_q[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the byte stream of the PS/2 receiver FIFO (`ps2_keyboard`) and turns it into key events. It pops bytes with the receiver's `nextdata_n` handshake, folds the `F0` (break) and `E0` (extended) prefixes into one event per key, and suppresses typematic repeats when counting. It exports the event, a press counter and an optional ASCII code. It sits between `ps2_keyboard` and the display/seven-segment logic in the top level.

## Interface
- `CNT_W`, default 8: press counter width.
- `clk` in 1: system clock; all logic on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `ps2_data` in 8: head byte of receiver FIFO (receiver `data`).
- `ps2_ready` in 1: FIFO non-empty (receiver `ready`).
- `ps2_overflow` in 1: receiver FIFO overflow flag.
- `nextdata_n` out 1: active-low pop strobe to receiver; high at reset.
- `key_valid` out 1: one-cycle event strobe; 0 at reset.
- `key_code` out 8: scan code of last event; 0 at reset.
- `key_ext` out 1: last event had `E0` prefix; 0 at reset.
- `key_down` out 1: 1 = make, 0 = break; 0 at reset.
- `key_repeat` out 1: make of the already-held code; 0 at reset.
- `key_ascii` out 8: ASCII of `key_code` (see Configuration); 0 at reset.
- `press_count` out CNT_W: count of new make events; 0 at reset.
- `ovf_sticky` out 1: set when `ps2_overflow`=1 is seen; cleared only by reset.

## Operation
- FSM states: IDLE, POP, GAP. Reset → IDLE.
- IDLE: if `ps2_ready`=1, latch `ps2_data` into `byte_q`, go to POP. Otherwise stay.
- POP: `nextdata_n`=0 for exactly this cycle. Classify `byte_q`:
  - `F0`: set `brk_pend`.
  - `E0`: set `ext_pend`.
  - Any other byte is an event byte:
    - `key_valid`=1; `key_code`=`byte_q`; `key_ext`=`ext_pend`; `key_down`=!`brk_pend`.
    - Then clear both pending flags.
  - Go to GAP.
- GAP: `nextdata_n`=1, which lets the receiver update `ready`/`data`. Go to IDLE.
- Held-key tracking uses `held_vld`, `held_code` and `held_ext`:
  - Make with `{ext,code}` equal to the held key: `key_repeat`=1; `press_count` unchanged.
  - Make of any other key: `key_repeat`=0; `press_count` += 1, wrapping 2^CNT_W−1 → 0; becomes the held key.
  - Break of the held key: `held_vld`=0.
  - Break of any other key: held state unchanged.
  - `key_repeat`=0 on all breaks.
- `key_code`, `key_ext`, `key_down`, `key_repeat` and `key_ascii` hold their values between events.
- Prefix order `E0 F0 xx` gives ext=1, down=0. A bare `F0 F0` leaves `brk_pend` set; no event is emitted.
- `ovf_sticky` is sampled every cycle, independent of FSM state.
- `resetn`=0 in any state:
  - FSM returns to IDLE; all pending and held state is cleared.
  - All outputs take their reset values at the next edge.
  - A partially consumed prefix sequence is discarded.

## Timing
- Byte accepted at edge N (IDLE, `ps2_ready`=1). `nextdata_n`=0 and `key_valid` (if an event byte) are both asserted during cycle N+1. GAP is N+2. IDLE is N+3.
- Throughput: one byte per 3 cycles. A full make/break/extended sequence of k bytes takes 3k cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- `ps2_ready` is ignored in POP and GAP.

## Configuration
- `PS2_KEY_ASCII_EN` defined:
  - Instantiates the scan-code→ASCII lookup.
  - `key_ascii` updates with `key_code` on the same cycle.
  - Covers set-2 codes for a–z, 0–9, space (`29`→`0x20`) and enter (`5A`→`0x0D`).
  - Extended codes and unmapped codes give `0x00`.
- Macro undefined: `key_ascii` is tied to `8'h00` and no lookup logic exists.

## Structure
- Package `ps2_pkg`:
  - Constants `PS2_BREAK`=`8'hF0` and `PS2_EXT`=`8'hE0`.
  - FSM state typedef (IDLE/POP/GAP, 2-bit).
- Sub-module `ps2_scan2ascii`: purely combinational, 8-bit scan code in, 8-bit ASCII out. Present only under `PS2_KEY_ASCII_EN`.

## Test plan
- Send `1C` → one `key_valid` with code `1C`, down=1, ext=0, repeat=0, ascii `0x61`, `press_count`=1. `nextdata_n` is low for exactly one cycle, 1 cycle after acceptance.
- Send `1C F0 1C` → two events: make, then break (down=0, code `1C`). `press_count` stays 1.
- Send `15 15 15 F0 15` → three makes with repeat=0,1,1, then one break. `press_count`=1. Then `15` again → repeat=0, `press_count`=2.
- Send `E0 75 E0 F0 75` → two events, both ext=1, code `75`, down=1 then 0, ascii `0x00`.
- Preload `press_count`=255 (CNT_W=8), then a new make → wraps to 0. Pulse `ps2_overflow` for one cycle → `ovf_sticky`=1 until reset.
- Send `F0`, assert `resetn`=0 for 1 cycle, then send `1C` → make event (down=1), `press_count`=1, all other outputs at reset values before the event.
